uart_rx: RTL and testbench

UART receiver for the SoC peripheral block, sitting beside the existing TXD transmitter and driving the RXD pin path. It samples the asynchronous RXD line and recovers 8N1 frames, LSB first. Received bytes go into a single-entry holding register with a valid/ready handshake toward the IO register bank. Sticky overrun and framing-error flags are exposed for the UART status register.

---
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, recovered from an asynchronous RXD line.
// A single-entry holding register with valid/ready handshake feeds the IO register
// bank; sticky overrun and framing-error flags feed the UART status register.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a low level on the synchronized RXD
// START  | timing to mid start bit to confirm the start (reject glitches)
// DATA   | sampling 8 data bits at one-bit spacing, LSB first
// STOP   | sampling the stop bit; deliver byte or flag a framing error
// BREAK  | line held low after a bad stop bit; wait for it to go high
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       err_clear,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            ferr_q, ferr_d;

    logic            deliver;
    logic            frame_evt;
    logic            accept;
    logic            ovr_set;

    assign rxs = sync_q[SYNC_STAGES-1];

    // RXD synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RXD};
        end
    end

    // Frame recovery: next state, bit capture and deliver/error events.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        deliver   = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    if (!rxs) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    shift_d[bit_idx_q] = rxs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Baud counter restarts on every state change so sample points align to the edge.
    always_comb begin
        if (state_d != state_q || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Holding register, handshake and sticky flags (a new event beats err_clear).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        ovr_set = 1'b0;
        accept  = valid_q && rx_ready;
        if (accept) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        if (err_clear) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set)   ovr_d  = 1'b1;
        if (frame_evt) ferr_d = 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
    assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios followed by random frames
// checked against a frame-level model of the holding register and flags.
module tb_uart_rx;

    localparam int CPB = 104;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       err_clear = 1'b0;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .RXD(RXD),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err),
        .err_clear(err_clear),
        .rx_busy(rx_busy)
    );

    always #5 CLK = ~CLK;

    // Record every byte handed over by a valid && ready handshake.
    always @(negedge CLK) begin
        if (!RESET && rx_valid && rx_ready) acc_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            tick(CPB);
        end
        RXD = stop;
        tick(CPB);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    int         lat;
    logic       m_valid, m_ovr, m_ferr, r, bad;
    logic [7:0] m_data, b;
    int         g;

    initial begin
        // Reset state
        #2;
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ovr", rx_overrun, 1'b0);
        check("rst_ferr", rx_frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        tick(3);
        RESET = 1'b0;
        tick(5);

        // Single byte with latency measurement
        lat = -1;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int n = 1; n <= 1200; n++) begin
                    tick(1);
                    if (rx_valid === 1'b1) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        check("latency_window", (lat >= 990 && lat <= 992), 1);
        check("single_valid", rx_valid, 1'b1);
        check("single_data", rx_data, 8'h55);
        check("single_ovr", rx_overrun, 1'b0);
        check("single_ferr", rx_frame_err, 1'b0);
        pulse_ready();
        check("single_drop_valid", rx_valid, 1'b0);

        // Back-to-back frames, consumer always ready
        acc_q.delete();
        rx_ready = 1'b1;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(5);
        rx_ready = 1'b0;
        check("b2b_count", acc_q.size(), 2);
        check("b2b_first", (acc_q.size() > 0) ? acc_q[0] : 8'hxx, 8'hA3);
        check("b2b_second", (acc_q.size() > 1) ? acc_q[1] : 8'hxx, 8'h0F);
        check("b2b_ovr", rx_overrun, 1'b0);
        check("b2b_valid", rx_valid, 1'b0);

        // Overrun with consumer stalled
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", rx_overrun, 1'b1);
        pulse_clear();
        check("ovr_cleared", rx_overrun, 1'b0);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid_kept", rx_valid, 1'b1);

        // Reset in the middle of a frame
        send_frame(8'h33, 1'b1);
        check("pre_rst_ovr", rx_overrun, 1'b1);
        RXD = 1'b0;
        tick(CPB);
        RXD = 1'b1;
        tick(4 * CPB + CPB / 2);
        check("pre_rst_busy", rx_busy, 1'b1);
        RESET = 1'b1;
        #1;
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_ovr", rx_overrun, 1'b0);
        check("midrst_ferr", rx_frame_err, 1'b0);
        check("midrst_busy", rx_busy, 1'b0);
        tick(2);
        RESET = 1'b0;
        tick(3);
        send_frame(8'h3C, 1'b1);
        check("post_rst_valid", rx_valid, 1'b1);
        check("post_rst_data", rx_data, 8'h3C);
        pulse_ready();
        check("post_rst_drain", rx_valid, 1'b0);

        // Framing error followed by a held-low line
        send_frame(8'h7E, 1'b0);
        check("ferr_flag", rx_frame_err, 1'b1);
        check("ferr_valid", rx_valid, 1'b0);
        check("ferr_busy", rx_busy, 1'b1);
        tick(10 * CPB);
        pulse_clear();
        check("ferr_cleared", rx_frame_err, 1'b0);
        tick(19 * CPB);
        check("break_no_repeat", rx_frame_err, 1'b0);
        check("break_busy", rx_busy, 1'b1);
        check("break_valid", rx_valid, 1'b0);
        RXD = 1'b1;
        tick(4);
        check("break_exit_busy", rx_busy, 1'b0);
        tick(CPB);

        // Glitch rejection, then a good frame
        RXD = 1'b0;
        tick(20);
        RXD = 1'b1;
        tick(CPB);
        check("glitch_busy", rx_busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_flags", {rx_overrun, rx_frame_err}, 2'b00);
        send_frame(8'hC9, 1'b1);
        check("glitch_next_valid", rx_valid, 1'b1);
        check("glitch_next_data", rx_data, 8'hC9);
        pulse_ready();
        tick(CPB / 2);

        // Random frames against a frame-level model
        acc_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_data  = 8'hC9;
        for (int f = 0; f < 16; f++) begin
            r   = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 5) == 0);
            b   = 8'($urandom_range(0, 255));
            g   = int'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) begin
                pulse_clear();
                m_ovr  = 1'b0;
                m_ferr = 1'b0;
            end
            rx_ready = r;
            send_frame(b, !bad);
            if (r && m_valid) begin
                exp_q.push_back(m_data);
                m_valid = 1'b0;
            end
            if (bad) begin
                m_ferr = 1'b1;
            end else if (r) begin
                exp_q.push_back(b);
                m_data = b;
            end else if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = b;
            end else begin
                m_ovr = 1'b1;
            end
            check("rand_valid", rx_valid, m_valid);
            if (m_valid) check("rand_data", rx_data, m_data);
            check("rand_ovr", rx_overrun, m_ovr);
            check("rand_ferr", rx_frame_err, m_ferr);
            check("rand_acc_count", acc_q.size(), exp_q.size());
            RXD = 1'b1;
            tick(bad ? CPB + g : g);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            check("rand_acc_data", (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
